// File: rtl/req_ack_arbiter.sv
// req_ack_arbiter: round-robin arbiter funnelling NUM_REQ req/ack requesters onto one downstream req/ack target.
// Optional downstream response timeout is built when REQ_ACK_ARBITER_TIMEOUT_EN is defined.
module req_ack_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W = 32,
  parameter int RDATA_W = 32,
  parameter int TIMEOUT_CYC = 255,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        up_req,
  input  logic [NUM_REQ*DATA_W-1:0] up_data,
  output logic [NUM_REQ-1:0]        up_ack,
  output logic [RDATA_W-1:0]        up_rdata,
  output logic                      dn_req,
  output logic [DATA_W-1:0]         dn_data,
  input  logic                      dn_ack,
  input  logic [RDATA_W-1:0]        dn_rdata,
  output logic                      busy,
  output logic [GW-1:0]             grant_id,
  output logic                      timeout_err
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t r_state, w_nxt;
  logic [GW-1:0] r_ptr, r_grant, w_off, w_sel, w_nptr;
  logic [GW:0] w_sum;
  logic [NUM_REQ-1:0] w_rot;
  logic [DATA_W-1:0] r_dn_data;
  logic [RDATA_W-1:0] r_up_rdata;
  logic w_any, w_to;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("req_ack_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC at least 1");
  end

  // Round-robin pick: rotate requests so the search origin sits at bit 0, take the lowest set bit.
  always_comb begin
    w_rot = NUM_REQ'({up_req, up_req} >> r_ptr);
    w_any = |w_rot;
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) w_off = w_rot[k] ? GW'(k) : w_off;
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    w_sel = (w_sum >= (GW+1)'(NUM_REQ)) ? GW'(w_sum - (GW+1)'(NUM_REQ)) : GW'(w_sum);
    w_nptr = (w_sel == GW'(NUM_REQ - 1)) ? '0 : w_sel + GW'(1);
  end

  // Next-state: DONE always falls back to IDLE so up_req sampled there is never arbitrated.
  always_comb begin
    w_nxt = IDLE;
    w_nxt = (r_state == IDLE) ? (w_any ? WAIT : IDLE) :
            (r_state == WAIT) ? ((dn_ack || w_to) ? DONE : WAIT) : IDLE;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_nxt;
  end

  // Grant bookkeeping, payload capture and response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
      r_grant <= '0;
      r_dn_data <= '0;
      r_up_rdata <= '0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_grant <= w_sel;
        r_ptr <= w_nptr;
        r_dn_data <= up_data[int'(w_sel)*DATA_W +: DATA_W];
      end
      if (r_state == WAIT && (dn_ack || w_to)) r_up_rdata <= dn_ack ? dn_rdata : '0;
    end
  end

`ifdef REQ_ACK_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] r_cnt;
  logic r_terr;
  assign w_to = (r_state == WAIT) && !dn_ack && (r_cnt == CW'(TIMEOUT_CYC - 1));
  assign timeout_err = r_terr;
  // WAIT-cycle counter (zero outside WAIT, so it is clear on entry) and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_terr <= 1'b0;
    end else begin
      r_cnt <= (r_state == WAIT) ? r_cnt + CW'(1) : '0;
      if (w_to) r_terr <= 1'b1;
    end
  end
`else
  assign w_to = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign up_ack = (r_state == DONE) ? (NUM_REQ'(1) << r_grant) : '0;
  assign up_rdata = r_up_rdata;
  assign dn_req = (r_state == WAIT);
  assign dn_data = r_dn_data;
  assign busy = (r_state != IDLE);
  assign grant_id = r_grant;
endmodule
